// File: rtl/burst_read_master_wrap.sv
// Avalon-MM bursting read master: linear or circular-window reads into a show-ahead FIFO.
// Bursts never cross a MAXBURSTCOUNT-word boundary or the wrap end, and requests are credit-gated.
module burst_read_master_wrap #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURSTCOUNT   = 8,
    parameter int BURSTCOUNTWIDTH = 4,
    parameter int FIFODEPTH       = 64,
    parameter int FIFODEPTH_LOG2  = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       control_go,
    input  logic                       control_abort,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_wrap_enable,
    input  logic [ADDRESSWIDTH-1:0]    control_wrap_base,
    input  logic [ADDRESSWIDTH-1:0]    control_wrap_size,
    output logic                       control_busy,
    output logic                       control_done,
    output logic                       control_error,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);
    localparam int LOG2BE = $clog2(BYTEENABLEWIDTH);
    localparam int PW     = FIFODEPTH_LOG2 + 1;
    localparam logic [ADDRESSWIDTH-1:0] WORD_MASK  = ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK = ADDRESSWIDTH'(MAXBURSTCOUNT * BYTEENABLEWIDTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] BURST_MASK = ADDRESSWIDTH'(MAXBURSTCOUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [ADDRESSWIDTH-1:0]    address, remaining, wrap_base_q, wrap_end_q;
    logic                       wrap_en_q, aborted, abort_req, read_q, done_q, error_q;
    logic [BURSTCOUNTWIDTH-1:0] burst_q;
    logic [PW-1:0]              pending, pending_nxt, fifo_used;
    logic [FIFODEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DATAWIDTH-1:0]       mem [FIFODEPTH];

    logic [ADDRESSWIDTH-1:0] to_bound, rem_words, wrap_words, burst_words;
    logic [ADDRESSWIDTH-1:0] burst_bytes, next_addr, wrap_end_go;
    logic accept, stalled, abort_seen, beat_ok, fifo_wr, fifo_rd, flush, credit_ok, go_err;

    // Next burst length: min of words to the aligned boundary, words left, words to wrap end.
    always_comb begin
        to_bound    = ADDRESSWIDTH'(MAXBURSTCOUNT) - ((address >> LOG2BE) & BURST_MASK);
        rem_words   = remaining >> LOG2BE;
        wrap_words  = (wrap_end_q - address) >> LOG2BE;
        burst_words = to_bound;
        if (rem_words < burst_words)
            burst_words = rem_words;
        if (wrap_en_q && (wrap_words < burst_words))
            burst_words = wrap_words;
    end

    always_comb begin
        burst_bytes = ADDRESSWIDTH'(burst_q) << LOG2BE;
        next_addr   = address + burst_bytes;
        if (wrap_en_q && (next_addr == wrap_end_q))
            next_addr = wrap_base_q;
    end

    always_comb begin
        wrap_end_go = control_wrap_base + control_wrap_size;
        go_err = (|(control_read_base & WORD_MASK)) | (|(control_read_length & WORD_MASK));
        if (control_wrap_enable)
            go_err = go_err | (control_wrap_size == '0)
                            | (|(control_wrap_size & ALIGN_MASK))
                            | (|(control_wrap_base & ALIGN_MASK))
                            | (control_read_base < control_wrap_base)
                            | (control_read_base >= wrap_end_go);
    end

    assign accept      = read_q & ~master_waitrequest;
    assign stalled     = read_q & master_waitrequest;
    assign abort_seen  = control_abort | abort_req;
    assign beat_ok     = master_readdatavalid & (pending != '0);
    assign pending_nxt = pending + (accept ? PW'(burst_q) : PW'(0)) - (beat_ok ? PW'(1) : PW'(0));
    // Outstanding beats plus stored words plus the new burst must fit: the FIFO cannot overflow.
    assign credit_ok   = (ADDRESSWIDTH'(pending) + ADDRESSWIDTH'(fifo_used) + burst_words)
                         <= ADDRESSWIDTH'(FIFODEPTH);
    assign fifo_wr     = beat_ok & ~aborted & (state != IDLE);
    assign fifo_rd     = user_read_buffer & (fifo_used != '0);
    assign flush       = (state == DRAIN) & aborted & (pending_nxt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            address     <= '0;
            remaining   <= '0;
            wrap_base_q <= '0;
            wrap_end_q  <= '0;
            wrap_en_q   <= 1'b0;
            aborted     <= 1'b0;
            abort_req   <= 1'b0;
            read_q      <= 1'b0;
            burst_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            pending     <= '0;
        end else begin
            done_q  <= 1'b0;
            pending <= pending_nxt;
            case (state)
                IDLE: if (control_go) begin
                    error_q     <= go_err;
                    abort_req   <= 1'b0;
                    aborted     <= 1'b0;
                    address     <= control_read_base;
                    remaining   <= control_read_length;
                    wrap_en_q   <= control_wrap_enable;
                    wrap_base_q <= control_wrap_base;
                    wrap_end_q  <= wrap_end_go;
                    if (go_err || (control_read_length == '0))
                        done_q <= 1'b1;
                    else
                        state <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        read_q    <= 1'b0;
                        address   <= next_addr;
                        remaining <= remaining - burst_bytes;
                    end
                    // A stalled request must hold, so an abort is remembered until it is accepted.
                    if (stalled)
                        abort_req <= abort_seen;
                    else if (abort_seen) begin
                        state     <= DRAIN;
                        aborted   <= 1'b1;
                        abort_req <= 1'b0;
                    end else if (accept && (remaining == burst_bytes))
                        state <= DRAIN;
                    else if (!read_q && credit_ok) begin
                        read_q  <= 1'b1;
                        burst_q <= burst_words[BURSTCOUNTWIDTH-1:0];
                    end
                end
                DRAIN: if (pending_nxt == '0) begin
                    state   <= IDLE;
                    done_q  <= 1'b1;
                    aborted <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_used <= fifo_used + PW'(fifo_wr) - PW'(fifo_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= master_readdata;
    end

    assign control_busy        = (state != IDLE);
    assign control_done        = done_q;
    assign control_error       = error_q;
    assign user_data_available = (fifo_used != '0);
    assign user_buffer_data    = user_data_available ? mem[rd_ptr] : '0;
    assign master_address      = address;
    assign master_read         = read_q;
    assign master_byteenable   = '1;
    assign master_burstcount   = burst_q;
endmodule
